tdm_demux_rx: RTL and testbench

Receive end of the board's nibble time-division link. The transmit side scans the switch nibbles onto a 4-bit lane, one nibble per beat, and flags slot 0 with frame_start. This block re-assembles each frame into a staging buffer and commits it atomically to the LED bank. It also tracks lock and detects framing errors, and sits between the link pins and the top-level led output.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_ctr.sv | 32 +++
 rtl/tdm_demux_rx.sv | 156 +++++++++++++++
 tb/tb_tdm_demux_rx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the nibble TDM receiver (tdm_demux_rx).
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEF_LANES  = 4;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SLOT_W = $clog2(DEF_LANES);

  // Width of a counter that must hold slot indices 0..lanes-1 (lanes >= 2).
  function automatic int slot_w(input int lanes);
    return (lanes > 2) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for tdm_demux_rx: clear, load-1, increment, plus last-slot flag.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int SLOT_W = slot_w(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  // Controls are mutually exclusive in normal use; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + 1'b1;
    end
  end

  assign last = (slot == SLOT_W'(LANES - 1));

endmodule

// File: rtl/tdm_demux_rx.sv
// Nibble TDM link receiver: stages one frame and commits it atomically to led.
// Optional inter-beat watchdog compiled in with TDM_RX_TIMEOUT_EN.
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int LANES          = DEF_LANES,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_start,
  input  logic                   clear_err,
  output logic [LANES*WIDTH-1:0] led,
  output logic                   frame_done,
  output logic                   locked,
  output logic                   sync_err,
  output state_t                 dbg_state
);

  localparam int SLOT_W = slot_w(LANES);

  if (LANES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("tdm_demux_rx: LANES and TIMEOUT_CYCLES must both be >= 2");
  end

  // Handshake: a beat is accepted on any rising edge where en && din_valid;
  // there is no back-pressure, the receiver always consumes a valid beat.
  logic beat;
  assign beat = en && din_valid;

  state_t            state, state_n;
  logic [SLOT_W-1:0] slot, wr_idx;
  logic              last, ld1, inc, clr, wr_stage, commit, err, flush, to_hit;
  logic [WIDTH-1:0]  stage [LANES-1];

  tdm_slot_ctr #(.LANES(LANES), .SLOT_W(SLOT_W)) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load1 (ld1),
    .inc   (inc),
    .slot  (slot),
    .last  (last)
  );

`ifdef TDM_RX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (en) begin
      if (state != RECV || beat || to_hit) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == RECV) && en && !beat && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    ld1      = 1'b0;
    inc      = 1'b0;
    clr      = 1'b0;
    wr_stage = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          if (frame_start) begin
            ld1      = 1'b1;
            wr_stage = 1'b1;
            state_n  = RECV;
          end else if (locked) begin
            err = 1'b1;
          end
        end
      end
      RECV: begin
        if (beat) begin
          if (frame_start) begin
            // Short frame: restart staging with this beat as slot 0.
            err      = 1'b1;
            flush    = 1'b1;
            ld1      = 1'b1;
            wr_stage = 1'b1;
          end else if (last) begin
            commit  = 1'b1;
            clr     = 1'b1;
            state_n = IDLE;
          end else begin
            wr_stage = 1'b1;
            inc      = 1'b1;
          end
        end else if (to_hit) begin
          err     = 1'b1;
          flush   = 1'b1;
          clr     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign wr_idx = ld1 ? '0 : slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES - 1; k++) stage[k] <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < LANES - 1; k++) stage[k] <= '0;
      end
      if (wr_stage) stage[wr_idx] <= din;
    end
  end

  // The last beat bypasses staging so led updates on the same edge it arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      led        <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= commit;
      if (commit) begin
        for (int k = 0; k < LANES - 1; k++) led[k*WIDTH +: WIDTH] <= stage[k];
        led[(LANES-1)*WIDTH +: WIDTH] <= din;
        locked <= 1'b1;
      end
      if (err) begin
        sync_err <= 1'b1;
        locked   <= 1'b0;
      end else if (en && clear_err) begin
        sync_err <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx against a queue-based frame model.
module tb_tdm_demux_rx;
  import tdm_pkg::*;

  localparam int L     = 4;
  localparam int W     = 4;
  localparam int TB_TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en, din_valid, frame_start, clear_err;
  logic [W-1:0]   din;
  logic [L*W-1:0] led;
  logic           frame_done, locked, sync_err;
  state_t         dbg_state;

  int checks = 0;
  int errors = 0;

  tdm_demux_rx #(.LANES(L), .WIDTH(W), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .clear_err   (clear_err),
    .led         (led),
    .frame_done  (frame_done),
    .locked      (locked),
    .sync_err    (sync_err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]   frm_q[$];
  logic [L*W-1:0] exp_q[$];
  logic [L*W-1:0] m_led;
  logic           m_done, m_locked, m_err, m_in_frame;
`ifdef TDM_RX_TIMEOUT_EN
  int m_idle;
`endif

  function automatic state_t m_state();
    return m_in_frame ? RECV : IDLE;
  endfunction

  task automatic model_reset();
    frm_q.delete();
    exp_q.delete();
    m_led = '0; m_done = 0; m_locked = 0; m_err = 0; m_in_frame = 0;
`ifdef TDM_RX_TIMEOUT_EN
    m_idle = 0;
`endif
  endtask

  // Expected outputs after one rising edge, given the inputs sampled on it.
  task automatic model_edge();
    logic err;
    err = 0;
    m_done = 0;
`ifdef TDM_RX_TIMEOUT_EN
    if (en && !din_valid && m_in_frame) begin
      m_idle++;
      if (m_idle == TB_TO) begin
        err = 1; m_in_frame = 0; frm_q.delete(); m_idle = 0;
      end
    end
    if (en && din_valid) m_idle = 0;
`endif
    if (en && din_valid) begin
      if (frame_start) begin
        if (m_in_frame) err = 1;
        frm_q.delete();
        frm_q.push_back(din);
        m_in_frame = 1;
      end else if (!m_in_frame) begin
        if (m_locked) err = 1;
      end else begin
        frm_q.push_back(din);
        if (frm_q.size() == L) begin
          for (int k = 0; k < L; k++) m_led[k*W +: W] = frm_q[k];
          m_done = 1; m_locked = 1; m_in_frame = 0;
          frm_q.delete();
          exp_q.push_back(m_led);
        end
      end
    end
    if (err) begin
      m_err = 1; m_locked = 0;
    end else if (en && clear_err) begin
      m_err = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic e, input logic dv, input logic fs,
                       input logic [W-1:0] d, input logic clr);
    en = e; din_valid = dv; frame_start = fs; din = d; clear_err = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Scoreboard: every frame_done pulse must carry the next committed frame.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_sb: unexpected frame_done, led=%h", led);
      end else begin
        logic [L*W-1:0] e;
        e = exp_q.pop_front();
        if (led !== e) begin
          errors++;
          $display("FAIL commit_sb: led=%h expected %h", led, e);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; en = 0; din_valid = 0; frame_start = 0; din = '0; clear_err = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({led, frame_done, locked, sync_err, dbg_state} !== {(L*W)'(0), 1'b0, 1'b0, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL reset: led=%h done=%b lock=%b err=%b st=%0d", led, frame_done, locked, sync_err, dbg_state);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] d [4] = '{4'h9, 4'h5, 4'hA, 4'h6};
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, i == 0, d[i], 0);
      checks++;
      if ({led, frame_done, locked, sync_err, dbg_state} !== {m_led, m_done, m_locked, m_err, m_state()}) begin
        errors++;
        $display("FAIL single_step%0d: got %h/%b%b%b/%0d exp %h/%b%b%b/%0d", i, led, frame_done, locked, sync_err, dbg_state, m_led, m_done, m_locked, m_err, m_state());
      end
    end
    checks++;
    if ({led, frame_done, locked, sync_err} !== {16'h6A59, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_commit: led=%h done=%b lock=%b err=%b exp 6a59/1/1/0", led, frame_done, locked, sync_err);
    end
    apply(1, 0, 0, 4'h0, 0);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: frame_done=%b exp 0", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'hE, 4'hD, 4'hC};
    for (int i = 0; i < 8; i++) begin
      apply(1, 1, (i % 4) == 0, d[i], 0);
      checks++;
      if ({led, frame_done, locked, sync_err, dbg_state} !== {m_led, m_done, m_locked, m_err, m_state()}) begin
        errors++;
        $display("FAIL b2b_step%0d: got %h/%b%b%b exp %h/%b%b%b", i, led, frame_done, locked, sync_err, m_led, m_done, m_locked, m_err);
      end
      if (i == 3 || i == 7) begin
        checks++;
        if ({led, frame_done, sync_err} !== {(i == 3) ? 16'h4321 : 16'hCDEF, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL b2b_commit%0d: led=%h done=%b err=%b", i, led, frame_done, sync_err);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    logic [W-1:0] d [6] = '{4'h7, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, i == 0 || i == 2, d[i], 0);
      checks++;
      if ({led, frame_done, locked, sync_err, dbg_state} !== {m_led, m_done, m_locked, m_err, m_state()}) begin
        errors++;
        $display("FAIL short_step%0d: got %h/%b%b%b exp %h/%b%b%b", i, led, frame_done, locked, sync_err, m_led, m_done, m_locked, m_err);
      end
      if (i == 2) begin
        checks++;
        if ({led, locked, sync_err} !== {16'hCDEF, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL short_err: led=%h lock=%b err=%b exp cdef/0/1", led, locked, sync_err);
        end
      end
    end
    checks++;
    if ({led, locked, sync_err} !== {16'h4321, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL short_relock: led=%h lock=%b err=%b exp 4321/1/1", led, locked, sync_err);
    end
    apply(1, 0, 0, 4'h0, 1);
  endtask

  task automatic test_en_gap();
    apply(1, 1, 1, 4'h9, 0);
    apply(1, 1, 0, 4'h5, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), 0);
      checks++;
      if ({led, frame_done, locked, sync_err, dbg_state} !== {m_led, m_done, m_locked, m_err, m_state()}) begin
        errors++;
        $display("FAIL engap_hold%0d: got %h/%b%b%b exp %h/%b%b%b", i, led, frame_done, locked, sync_err, m_led, m_done, m_locked, m_err);
      end
    end
    apply(1, 1, 0, 4'hA, 0);
    apply(1, 1, 0, 4'h6, 0);
    checks++;
    if ({led, frame_done, sync_err} !== {16'h6A59, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL engap_commit: led=%h done=%b err=%b exp 6a59/1/0", led, frame_done, sync_err);
    end
  endtask

  task automatic test_err_clear();
    apply(1, 1, 0, 4'h3, 0);
    checks++;
    if ({sync_err, locked, led} !== {1'b1, 1'b0, 16'h6A59}) begin
      errors++;
      $display("FAIL orphan: err=%b lock=%b led=%h exp 1/0/6a59", sync_err, locked, led);
    end
    apply(1, 0, 0, 4'h0, 1);
    checks++;
    if (sync_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: sync_err=%b exp 0", sync_err);
    end
    apply(1, 1, 1, 4'h1, 0);
    apply(1, 1, 0, 4'h2, 0);
    apply(1, 1, 1, 4'h5, 1);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL err_wins: sync_err=%b exp 1", sync_err);
    end
    apply(1, 1, 0, 4'h6, 0);
    apply(1, 1, 0, 4'h7, 0);
    apply(1, 1, 0, 4'h8, 0);
    checks++;
    if ({led, frame_done, locked} !== {16'h8765, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL err_recover: led=%h done=%b lock=%b exp 8765/1/1", led, frame_done, locked);
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 1, 1, 4'h9, 0);
    apply(1, 1, 0, 4'h5, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({led, frame_done, locked, sync_err, dbg_state} !== {(L*W)'(0), 1'b0, 1'b0, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL reset_mid: led=%h done=%b lock=%b err=%b st=%0d", led, frame_done, locked, sync_err, dbg_state);
    end
    @(negedge clk);
    rst_n = 1;
    apply(1, 1, 0, 4'hA, 0);
    checks++;
    if ({led, locked, sync_err, dbg_state} !== {(L*W)'(0), 1'b0, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL unlocked_orphan: led=%h lock=%b err=%b st=%0d exp 0/0/0/IDLE", led, locked, sync_err, dbg_state);
    end
  endtask

`ifdef TDM_RX_TIMEOUT_EN
  task automatic test_timeout();
    apply(1, 1, 1, 4'h1, 0);
    apply(1, 1, 0, 4'h2, 0);
    for (int i = 1; i <= TB_TO; i++) begin
      apply(1, 0, 0, 4'h0, 0);
      checks++;
      if ({sync_err, locked, dbg_state} !== {(i == TB_TO), 1'b0, (i == TB_TO) ? IDLE : RECV}) begin
        errors++;
        $display("FAIL timeout_cyc%0d: err=%b lock=%b st=%0d", i, sync_err, locked, dbg_state);
      end
    end
    apply(1, 0, 0, 4'h0, 1);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 5) == 0), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 7) == 0));
      checks++;
      if ({led, frame_done, locked, sync_err, dbg_state} !== {m_led, m_done, m_locked, m_err, m_state()}) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h/%b%b%b/%0d exp %h/%b%b%b/%0d", i, led, frame_done, locked, sync_err, dbg_state, m_led, m_done, m_locked, m_err, m_state());
      end
    end
    apply(0, 0, 0, 4'h0, 0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_en_gap();
    test_err_clear();
    test_reset_mid();
`ifdef TDM_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d committed frames never observed, exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

endmodule
